// File: rtl/cache_ctrl.sv
// Sequencing FSM for a 16-set, 32-byte-line, write-back direct-mapped D-cache:
// hit/miss detection, dirty writeback, refill, tag update and hit/miss statistics.
module cache_ctrl #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_valid_i,
    input  logic              cpu_req_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_ready_o,
    output logic              cpu_busy_o,
    output logic [3:0]        tag_index_o,
    input  logic [ADDR_W-8:0] tag_read_i,
    output logic              tag_we_o,
    output logic [ADDR_W-8:0] tag_write_o,
    output logic              data_we_o,
    output logic              data_refill_o,
    output logic              mem_req_valid_o,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int TAG_W = ADDR_W - 9;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic              replay_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;

    logic              latch_s;
    logic              hit_inc_s;
    logic              miss_inc_s;
    logic              hit_s;
    logic              victim_dirty_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic [3:0]        index_s;

    assign req_tag_s      = addr_r[ADDR_W-1:9];
    assign index_s        = addr_r[8:5];
    assign hit_s          = tag_read_i[TAG_W+1] && (tag_read_i[TAG_W-1:0] == req_tag_s);
    assign victim_dirty_s = tag_read_i[TAG_W+1] && tag_read_i[TAG_W];

    assign tag_index_o = index_s;
    assign cpu_busy_o  = (state_r != ST_IDLE);
    assign hit_cnt_o   = hit_cnt_r;
    assign miss_cnt_o  = miss_cnt_r;

    // State, latched request and statistics registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            we_r       <= 1'b0;
            replay_r   <= 1'b0;
            hit_cnt_r  <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (latch_s) begin
                addr_r <= cpu_addr_i;
                we_r   <= cpu_req_we_i;
            end
            // COMPARE is only ever entered from IDLE or ALLOCATE, so this marks the replay pass
            replay_r <= (state_r == ST_ALLOCATE);
            if (hit_inc_s) begin
                hit_cnt_r <= hit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_inc_s) begin
                miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next_s    = state_r;
        latch_s         = 1'b0;
        hit_inc_s       = 1'b0;
        miss_inc_s      = 1'b0;
        cpu_ready_o     = 1'b0;
        tag_we_o        = 1'b0;
        tag_write_o     = {(TAG_W+2){1'b0}};
        data_we_o       = 1'b0;
        data_refill_o   = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_addr_o      = {ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_valid_i) begin
                    latch_s      = 1'b1;
                    state_next_s = ST_COMPARE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                if (hit_s) begin
                    cpu_ready_o  = 1'b1;
                    hit_inc_s    = !replay_r;
                    state_next_s = ST_IDLE;
                    if (we_r) begin
                        tag_we_o    = 1'b1;
                        tag_write_o = {1'b1, 1'b1, req_tag_s};
                        data_we_o   = 1'b1;
                    end else begin
                        tag_we_o    = 1'b0;
                    end
                end else begin
                    miss_inc_s = 1'b1;
                    if (victim_dirty_s) begin
                        state_next_s = ST_WRITEBACK;
                    end else begin
                        state_next_s = ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_addr_o      = {tag_read_i[TAG_W-1:0], index_s, 5'b00000};
                if (mem_ready_i) begin
                    state_next_s = ST_ALLOCATE;
                end else begin
                    state_next_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = {req_tag_s, index_s, 5'b00000};
                if (mem_ready_i) begin
                    tag_we_o      = 1'b1;
                    tag_write_o   = {1'b1, 1'b0, req_tag_s};
                    data_refill_o = 1'b1;
                    state_next_s  = ST_COMPARE;
                end else begin
                    state_next_s  = ST_ALLOCATE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: acts as tag store and memory, and checks every access
// against a set-level cache model (valid/dirty/tag per set, hit and miss tallies).
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_we = 1'b0;
    logic [63:0] cpu_addr = 64'd0;
    logic        cpu_ready;
    logic        cpu_busy;
    logic [3:0]  tag_index;
    logic [56:0] tag_read;
    logic        tag_we;
    logic [56:0] tag_write;
    logic        data_we;
    logic        data_refill;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [63:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [56:0] env_tag [16];

    bit          m_valid [16];
    bit          m_dirty [16];
    logic [54:0] m_tag   [16];
    int          m_hits = 0;
    int          m_misses = 0;

    logic [54:0] tag_pool [4];

    always #5 clk = ~clk;

    cache_ctrl #(.ADDR_W(64), .CNT_W(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cpu_req_valid_i (cpu_req_valid),
        .cpu_req_we_i    (cpu_req_we),
        .cpu_addr_i      (cpu_addr),
        .cpu_ready_o     (cpu_ready),
        .cpu_busy_o      (cpu_busy),
        .tag_index_o     (tag_index),
        .tag_read_i      (tag_read),
        .tag_we_o        (tag_we),
        .tag_write_o     (tag_write),
        .data_we_o       (data_we),
        .data_refill_o   (data_refill),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_we_o    (mem_req_we),
        .mem_addr_o      (mem_addr),
        .mem_ready_i     (mem_ready),
        .hit_cnt_o       (hit_cnt),
        .miss_cnt_o      (miss_cnt)
    );

    // Tag store: combinational read, clocked write, cleared by the shared reset
    assign tag_read = env_tag[tag_index];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) env_tag[i] <= 57'd0;
        end else if (tag_we) begin
            env_tag[tag_index] <= tag_write;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 55'd0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One complete CPU access; dwb/dal are extra memory wait cycles for writeback/fetch
    task automatic run_txn(input logic [63:0] a, input logic w, input int dwb, input int dal);
        logic [3:0]  idx;
        logic [54:0] tg;
        bit          exp_hit;
        bit          exp_wb;
        logic [63:0] exp_wb_addr;
        logic [63:0] exp_fetch;
        int          exp_lat;
        int          n;
        bit          done;
        int          wb_cyc;
        int          al_cyc;
        int          addr_err;
        int          busy_err;
        int          dwe;
        int          refill;
        int          overlap;
        int          phase;
        int          prev_phase;
        int          cnt;

        idx         = a[8:5];
        tg          = a[63:9];
        exp_hit     = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
        exp_wb_addr = {m_tag[idx], idx, 5'b00000};
        exp_fetch   = {tg, idx, 5'b00000};
        exp_lat     = exp_hit ? 2 : (3 + (exp_wb ? dwb + 1 : 0) + dal + 1);

        if (exp_hit) begin
            m_hits++;
            if (w) m_dirty[idx] = 1'b1;
        end else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = w;
            m_tag[idx]   = tg;
        end

        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = w;
        cpu_addr      = a;
        mem_ready     = 1'b0;
        #1;
        check_val("busy_on_request", 64'(cpu_busy), 64'd0);

        n = 1; done = 0; wb_cyc = 0; al_cyc = 0; addr_err = 0; busy_err = 0;
        dwe = 0; refill = 0; overlap = 0; prev_phase = 0; cnt = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            cpu_req_valid = 1'($urandom_range(0, 1));
            cpu_req_we    = 1'($urandom_range(0, 1));
            cpu_addr      = {$urandom, $urandom};
            #1;
            if (mem_req_valid) begin
                phase = mem_req_we ? 1 : 2;
                if (phase != prev_phase) cnt = 0;
                if (phase == 1) begin
                    wb_cyc++;
                    if (!exp_wb || mem_addr !== exp_wb_addr) addr_err++;
                    mem_ready = (cnt == dwb);
                end else begin
                    al_cyc++;
                    if (mem_addr !== exp_fetch) addr_err++;
                    mem_ready = (cnt == dal);
                end
                cnt++;
                prev_phase = phase;
            end else begin
                mem_ready  = 1'b0;
                prev_phase = 0;
            end
            #1;
            if (!cpu_busy) busy_err++;
            if (data_we) dwe++;
            if (data_refill) refill++;
            if (data_we && data_refill) overlap++;
            if (cpu_ready) done = 1;
        end
        cpu_req_valid = 1'b0;
        mem_ready     = 1'b0;

        check_val("latency", 64'(n), 64'(exp_lat));
        check_val("writeback_cycles", 64'(wb_cyc), exp_wb ? 64'(dwb + 1) : 64'd0);
        check_val("fetch_cycles", 64'(al_cyc), exp_hit ? 64'd0 : 64'(dal + 1));
        check_val("mem_addr", 64'(addr_err), 64'd0);
        check_val("busy_while_active", 64'(busy_err), 64'd0);
        check_val("data_we_count", 64'(dwe), 64'(w));
        check_val("refill_count", 64'(refill), exp_hit ? 64'd0 : 64'd1);
        check_val("we_refill_overlap", 64'(overlap), 64'd0);

        @(posedge clk);
        #1;
        check_val("busy_after_done", 64'(cpu_busy), 64'd0);
        check_val("tag_entry", 64'(env_tag[idx]), 64'({m_valid[idx], m_dirty[idx], m_tag[idx]}));
        check_val("hit_cnt", 64'(hit_cnt), 64'(m_hits));
        check_val("miss_cnt", 64'(miss_cnt), 64'(m_misses));
    endtask

    initial begin
        logic [63:0] r64;
        logic [63:0] a;
        int          guard;

        model_clear();
        tag_pool[0] = 55'h8;
        tag_pool[1] = 55'h18;
        tag_pool[2] = 55'h40_0000_0000_0008;
        r64 = {$urandom, $urandom};
        tag_pool[3] = r64[54:0];

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", 64'(cpu_busy), 64'd0);
        check_val("rst_mem_req", 64'(mem_req_valid), 64'd0);
        check_val("rst_ready", 64'(cpu_ready), 64'd0);
        check_val("rst_index", 64'(tag_index), 64'd0);
        check_val("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check_val("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(64'h1000, 1'b0, 0, 2);
        check_val("first_tag_write", 64'(env_tag[0]), 64'({1'b1, 1'b0, 55'h8}));
        run_txn(64'h1000, 1'b0, 0, 0);
        run_txn(64'h1008, 1'b1, 0, 0);
        check_val("store_tag_write", 64'(env_tag[0]), 64'({1'b1, 1'b1, 55'h8}));
        run_txn(64'h3000, 1'b0, 1, 1);
        check_val("dirty_miss_tag", 64'(env_tag[0]), 64'({1'b1, 1'b0, 55'h18}));
        run_txn(64'h5020, 1'b0, 0, 10);
        run_txn(64'h7040, 1'b1, 0, 3);

        // Reset in the middle of a writeback: set 0 is made dirty, then a conflicting load
        run_txn(64'h3000, 1'b1, 0, 0);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_addr      = 64'h5000;
        mem_ready     = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            #1;
            guard++;
        end while (!(mem_req_valid && mem_req_we) && guard < 20);
        check_val("reached_writeback", 64'(mem_req_valid && mem_req_we), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_drops_mem_req", 64'(mem_req_valid), 64'd0);
        check_val("rst_mid_busy", 64'(cpu_busy), 64'd0);
        check_val("rst_mid_hit_cnt", 64'(hit_cnt), 64'd0);
        check_val("rst_mid_miss_cnt", 64'(miss_cnt), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        run_txn(64'h5000, 1'b0, 0, 1);

        for (int t = 0; t < 80; t++) begin
            a = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
            run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
